// File: rtl/ports_sfr_ctrl.sv
// -----------------------------------------------------------------------------
// ports_sfr_ctrl
//   SFR-bus controller for the PORT_TOP I/O block. Owns the P0..P4 data
//   latches and the P0EN..P3EN direction registers. A three-state sequencer
//   (IDLE -> ACCESS -> ACK) serves one core SFR read or write at a time, and
//   the asynchronous pin values coming back from PORT_TOP are synchronised
//   through two flops per bit before anything looks at them.
//
// Ports
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   sfr_req_i                     request, held by the core until sfr_ack_o
//   sfr_we_i / sfr_rmw_i          write strobe / read-modify-write read (latch)
//   sfr_addr_i, sfr_wdata_i       address and write data, latched with req
//   sfr_rdata_o, sfr_ack_o        read data (valid with ack), one-cycle ack
//   pin_p0_i..pin_p3_i            asynchronous pin values from PORT_TOP
//   ports_sfr_P0_o..P4_o          data latches to PORT_TOP (reset 8'hFF)
//   ports_sfr_P0EN_o..P3EN_o      direction registers, 1 = output (reset 8'h00)
//   irq_o                         pin-change interrupt
//
// Build option
//   PORTS_PCINT_EN : adds the port-3 pin-change interrupt with PCMSK (8'h98)
//                    and write-1-to-clear PCFLG (8'h99). Without it those
//                    addresses are unmapped and irq_o is tied low.
// -----------------------------------------------------------------------------
module ports_sfr_ctrl #(
  parameter logic [7:0] P_BASE   = 8'h80,
  parameter logic [7:0] PEN_BASE = 8'h94
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sfr_req_i,
  input  logic       sfr_we_i,
  input  logic       sfr_rmw_i,
  input  logic [7:0] sfr_addr_i,
  input  logic [7:0] sfr_wdata_i,
  output logic [7:0] sfr_rdata_o,
  output logic       sfr_ack_o,
  input  logic [7:0] pin_p0_i,
  input  logic [7:0] pin_p1_i,
  input  logic [7:0] pin_p2_i,
  input  logic [7:0] pin_p3_i,
  output logic [7:0] ports_sfr_P0_o,
  output logic [7:0] ports_sfr_P1_o,
  output logic [7:0] ports_sfr_P2_o,
  output logic [7:0] ports_sfr_P3_o,
  output logic [7:0] ports_sfr_P4_o,
  output logic [7:0] ports_sfr_P0EN_o,
  output logic [7:0] ports_sfr_P1EN_o,
  output logic [7:0] ports_sfr_P2EN_o,
  output logic [7:0] ports_sfr_P3EN_o,
  output logic       irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic            we_r, rmw_r;
  logic [7:0]      addr_r, wdata_r;
  logic [3:0][7:0] pin_s, sync1_r, sync2_r;
  logic [4:0][7:0] p_r;
  logic [3:0][7:0] pen_r;
  logic [4:0]      hit_p_s;
  logic [3:0]      hit_pen_s;
  logic            wr_s;
  logic [7:0]      rdata_s, rdata_r;
  logic            ack_r;

  assign pin_s = {pin_p3_i, pin_p2_i, pin_p1_i, pin_p0_i};
  assign wr_s  = (state_r == ST_ACCESS) && we_r;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // FSM next state: req is only looked at in IDLE, so a held req starts the
  // next access one cycle after the ack cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sfr_req_i) state_next_s = ST_ACCESS;
        else           state_next_s = ST_IDLE;
      end
      ST_ACCESS: state_next_s = ST_ACK;
      ST_ACK:    state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Request capture: later input changes cannot disturb an access in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_r    <= 1'b0;
      rmw_r   <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
    end else if ((state_r == ST_IDLE) && sfr_req_i) begin
      we_r    <= sfr_we_i;
      rmw_r   <= sfr_rmw_i;
      addr_r  <= sfr_addr_i;
      wdata_r <= sfr_wdata_i;
    end
  end

  // Two-flop pin synchroniser; only stage 2 is ever consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_r <= {4{8'h00}};
      sync2_r <= {4{8'h00}};
    end else begin
      sync1_r <= pin_s;
      sync2_r <= sync1_r;
    end
  end

  // Address decode of the latched address
  always_comb begin
    hit_p_s   = 5'd0;
    hit_pen_s = 4'd0;
    for (int n = 0; n < 5; n++) hit_p_s[n]   = (addr_r == (P_BASE + 8'(n * 16)));
    for (int n = 0; n < 4; n++) hit_pen_s[n] = (addr_r == (PEN_BASE + 8'(n)));
  end

  // Port latches and direction registers: full-byte replace on write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_r   <= {5{8'hFF}};
      pen_r <= {4{8'h00}};
    end else begin
      for (int n = 0; n < 5; n++) if (wr_s && hit_p_s[n])   p_r[n]   <= wdata_r;
      for (int n = 0; n < 4; n++) if (wr_s && hit_pen_s[n]) pen_r[n] <= wdata_r;
    end
  end

`ifdef PORTS_PCINT_EN
  localparam logic [7:0] PCMSK_ADDR = 8'h98;
  localparam logic [7:0] PCFLG_ADDR = 8'h99;

  logic [7:0] pcmsk_r, pcflg_r, pc_prev_r;
  logic [7:0] pc_set_s, pc_clr_s, pcflg_next_s;
  logic       irq_r;

  // Pin-change flag update: set has priority over a same-edge clear
  always_comb begin
    pc_set_s     = (sync2_r[3] ^ pc_prev_r) & pcmsk_r;
    pc_clr_s     = (wr_s && (addr_r == PCFLG_ADDR)) ? wdata_r : 8'h00;
    pcflg_next_s = (pcflg_r & ~pc_clr_s) | pc_set_s;
  end

  // Pin-change registers; irq follows the flags on the same edge they set
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pcmsk_r   <= 8'h00;
      pcflg_r   <= 8'h00;
      pc_prev_r <= 8'h00;
      irq_r     <= 1'b0;
    end else begin
      if (wr_s && (addr_r == PCMSK_ADDR)) pcmsk_r <= wdata_r;
      pcflg_r   <= pcflg_next_s;
      pc_prev_r <= sync2_r[3];
      irq_r     <= |pcflg_next_s;
    end
  end

  assign irq_o = irq_r;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux: hits are one-hot, so an AND-OR tree suffices; unmapped -> 00
  always_comb begin
    rdata_s = 8'h00;
    for (int n = 0; n < 4; n++)
      rdata_s = rdata_s | ({8{hit_p_s[n]}} & (rmw_r ? p_r[n] : sync2_r[n]));
    rdata_s = rdata_s | ({8{hit_p_s[4]}} & p_r[4]);
    for (int n = 0; n < 4; n++)
      rdata_s = rdata_s | ({8{hit_pen_s[n]}} & pen_r[n]);
`ifdef PORTS_PCINT_EN
    rdata_s = rdata_s | ({8{addr_r == PCMSK_ADDR}} & pcmsk_r);
    rdata_s = rdata_s | ({8{addr_r == PCFLG_ADDR}} & pcflg_r);
`endif
  end

  // Response registers: rdata reloads only in ACCESS, ack marks the ACK cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_r <= 8'h00;
      ack_r   <= 1'b0;
    end else begin
      if (state_r == ST_ACCESS) rdata_r <= rdata_s;
      ack_r <= (state_r == ST_ACCESS);
    end
  end

  assign sfr_rdata_o      = rdata_r;
  assign sfr_ack_o        = ack_r;
  assign ports_sfr_P0_o   = p_r[0];
  assign ports_sfr_P1_o   = p_r[1];
  assign ports_sfr_P2_o   = p_r[2];
  assign ports_sfr_P3_o   = p_r[3];
  assign ports_sfr_P4_o   = p_r[4];
  assign ports_sfr_P0EN_o = pen_r[0];
  assign ports_sfr_P1EN_o = pen_r[1];
  assign ports_sfr_P2EN_o = pen_r[2];
  assign ports_sfr_P3EN_o = pen_r[3];

endmodule

// File: tb/tb_ports_sfr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ports_sfr_ctrl
//   Directed self-checking bench for ports_sfr_ctrl. Inputs are driven on the
//   falling edge and outputs are sampled on the falling edge, half a cycle
//   away from the rising edge the design uses.
// -----------------------------------------------------------------------------
module tb_ports_sfr_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       sfr_req_i = 1'b0, sfr_we_i = 1'b0, sfr_rmw_i = 1'b0;
  logic [7:0] sfr_addr_i = 8'h00, sfr_wdata_i = 8'h00;
  logic [7:0] sfr_rdata_o;
  logic       sfr_ack_o;
  logic [7:0] pin_p0_i = 8'h00, pin_p1_i = 8'h00, pin_p2_i = 8'h00, pin_p3_i = 8'h00;
  logic [7:0] p0_o, p1_o, p2_o, p3_o, p4_o;
  logic [7:0] p0en_o, p1en_o, p2en_o, p3en_o;
  logic       irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  ports_sfr_ctrl dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .sfr_req_i        (sfr_req_i),
    .sfr_we_i         (sfr_we_i),
    .sfr_rmw_i        (sfr_rmw_i),
    .sfr_addr_i       (sfr_addr_i),
    .sfr_wdata_i      (sfr_wdata_i),
    .sfr_rdata_o      (sfr_rdata_o),
    .sfr_ack_o        (sfr_ack_o),
    .pin_p0_i         (pin_p0_i),
    .pin_p1_i         (pin_p1_i),
    .pin_p2_i         (pin_p2_i),
    .pin_p3_i         (pin_p3_i),
    .ports_sfr_P0_o   (p0_o),
    .ports_sfr_P1_o   (p1_o),
    .ports_sfr_P2_o   (p2_o),
    .ports_sfr_P3_o   (p3_o),
    .ports_sfr_P4_o   (p4_o),
    .ports_sfr_P0EN_o (p0en_o),
    .ports_sfr_P1EN_o (p1en_o),
    .ports_sfr_P2EN_o (p2en_o),
    .ports_sfr_P3EN_o (p3en_o),
    .irq_o            (irq_o)
  );

  // Single comparison point: counts and reports
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One access: raise req, wait (bounded) for ack, drop req in the ack cycle.
  // lat counts falling edges from the req-sampling edge to the ack cycle.
  task automatic sfr_access(input logic we, input logic rmw, input logic [7:0] addr,
                            input logic [7:0] wdata, output logic [7:0] rd, output int lat);
    @(negedge clk_i);
    sfr_req_i = 1'b1; sfr_we_i = we; sfr_rmw_i = rmw;
    sfr_addr_i = addr; sfr_wdata_i = wdata;
    lat = 0;
    do begin
      @(negedge clk_i);
      lat++;
    end while (!sfr_ack_o && lat < 10);
    rd = sfr_rdata_o;
    sfr_req_i = 1'b0; sfr_we_i = 1'b0; sfr_rmw_i = 1'b0;
  endtask

  logic [7:0] rd, v;
  int lat, gap;

  initial begin
    // ---------------- reset state ----------------
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_P0", p0_o, 8'hFF);
    check_eq("rst_P4", p4_o, 8'hFF);
    check_eq("rst_P1EN", p1en_o, 8'h00);
    check_eq("rst_ack", sfr_ack_o, 1'b0);
    check_eq("rst_rdata", sfr_rdata_o, 8'h00);
    check_eq("rst_irq", irq_o, 1'b0);

    // ---------------- T2: write P1, exact timing ----------------
    sfr_req_i = 1'b1; sfr_we_i = 1'b1; sfr_addr_i = 8'h90; sfr_wdata_i = 8'hA5;
    @(negedge clk_i);                     // after edge N (ACCESS)
    check_eq("t2_p1_before", p1_o, 8'hFF);
    check_eq("t2_ack_n", sfr_ack_o, 1'b0);
    @(negedge clk_i);                     // after edge N+1 (ACK)
    check_eq("t2_p1_after", p1_o, 8'hA5);
    check_eq("t2_ack_n1", sfr_ack_o, 1'b1);
    sfr_req_i = 1'b0; sfr_we_i = 1'b0;
    @(negedge clk_i);
    check_eq("t2_ack_n2", sfr_ack_o, 1'b0);

    // ---------------- T1: reset mid-ACCESS drops the write ----------------
    sfr_req_i = 1'b1; sfr_we_i = 1'b1; sfr_addr_i = 8'h80; sfr_wdata_i = 8'h00;
    @(negedge clk_i);                     // now in ACCESS
    rst_i = 1'b1;
    sfr_req_i = 1'b0; sfr_we_i = 1'b0;
    @(negedge clk_i);
    check_eq("t1_p0", p0_o, 8'hFF);
    check_eq("t1_p1", p1_o, 8'hFF);
    check_eq("t1_ack", sfr_ack_o, 1'b0);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("t1_ack_late", sfr_ack_o, 1'b0);
    check_eq("t1_p0_late", p0_o, 8'hFF);
    sfr_access(1'b0, 1'b1, 8'h80, 8'h00, rd, lat);
    check_eq("t1_idle_lat", lat, 2);
    check_eq("t1_rd_p0", rd, 8'hFF);

    // ---------------- T3: pin vs latch ----------------
    pin_p2_i = 8'h3C;
    repeat (3) @(negedge clk_i);
    sfr_access(1'b0, 1'b0, 8'hA0, 8'h00, rd, lat);
    check_eq("t3_pin", rd, 8'h3C);
    sfr_access(1'b0, 1'b1, 8'hA0, 8'h00, rd, lat);
    check_eq("t3_latch", rd, 8'hFF);
    repeat (3) @(negedge clk_i);
    check_eq("t3_rdata_hold", sfr_rdata_o, 8'hFF);

    // ---------------- T4: boundaries ----------------
    sfr_access(1'b1, 1'b0, 8'h97, 8'h5A, rd, lat);
    check_eq("t4_p3en_out", p3en_o, 8'h5A);
    sfr_access(1'b0, 1'b0, 8'h97, 8'h00, rd, lat);
    check_eq("t4_p3en_rd", rd, 8'h5A);
    sfr_access(1'b1, 1'b0, 8'hC0, 8'h12, rd, lat);
    sfr_access(1'b0, 1'b0, 8'hC0, 8'h00, rd, lat);
    check_eq("t4_p4_rd", rd, 8'h12);
    check_eq("t4_p4_out", p4_o, 8'h12);
    sfr_access(1'b1, 1'b0, 8'h94, 8'h0F, rd, lat);
    check_eq("t4_p0en_out", p0en_o, 8'h0F);
    sfr_access(1'b1, 1'b0, 8'h81, 8'h00, rd, lat);   // unmapped write
    check_eq("t4_unmap_wr_lat", lat, 2);
    check_eq("t4_unmap_p0", p0_o, 8'hFF);
`ifndef PORTS_PCINT_EN
    sfr_access(1'b0, 1'b0, 8'h98, 8'h00, rd, lat);
    check_eq("t4_98_lat", lat, 2);
    check_eq("t4_98_rd", rd, 8'h00);
`endif
    // Back-to-back: req held through the ack
    @(negedge clk_i);
    sfr_req_i = 1'b1; sfr_we_i = 1'b0; sfr_addr_i = 8'h97;
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!sfr_ack_o && lat < 10);
    check_eq("t4_b2b_first", lat, 2);
    gap = 0;
    do begin @(negedge clk_i); gap++; end while (!sfr_ack_o && gap < 10);
    check_eq("t4_b2b_gap", gap, 3);
    check_eq("t4_b2b_rd", sfr_rdata_o, 8'h5A);
    sfr_req_i = 1'b0;
    @(negedge clk_i);
    check_eq("t4_b2b_ack_off", sfr_ack_o, 1'b0);

    // ---------------- T5: pin-change interrupt ----------------
`ifdef PORTS_PCINT_EN
    sfr_access(1'b1, 1'b0, 8'h98, 8'h01, rd, lat);
    sfr_access(1'b0, 1'b0, 8'h98, 8'h00, rd, lat);
    check_eq("t5_pcmsk_rd", rd, 8'h01);
    @(negedge clk_i);
    pin_p3_i = pin_p3_i ^ 8'h01;
    lat = 0;
    do begin @(negedge clk_i); lat++; end while (!irq_o && lat < 4);
    check_eq("t5_irq_set", irq_o, 1'b1);
    pin_p3_i = pin_p3_i ^ 8'h01;          // toggle again, then clear
    sfr_access(1'b1, 1'b0, 8'h99, 8'h01, rd, lat);
    repeat (3) @(negedge clk_i);
    sfr_access(1'b0, 1'b0, 8'h99, 8'h00, rd, lat);
    check_eq("t5_flag_kept", rd, 8'h01);
    check_eq("t5_irq_kept", irq_o, 1'b1);
    sfr_access(1'b1, 1'b0, 8'h99, 8'h01, rd, lat);
    @(negedge clk_i);
    check_eq("t5_irq_clr", irq_o, 1'b0);
`else
    pin_p3_i = pin_p3_i ^ 8'hFF;
    repeat (5) @(negedge clk_i);
    check_eq("t5_irq_tied", irq_o, 1'b0);
`endif

    // ---------------- T6: asynchronous pin changes ----------------
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 5; j++) begin
        pin_p0_i = 8'($urandom);
        @(negedge clk_i);
      end
      v = 8'($urandom);
      pin_p0_i = v;
      repeat (2) @(negedge clk_i);
      sfr_access(1'b0, 1'b0, 8'h80, 8'h00, rd, lat);
      check_eq("t6_sync_rd", rd, v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
